// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card initialisation sequencer: power-up wait, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Drives the command fields of sd_controller and checks each R1/R7/OCR response it returns.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | out of reset, waiting for start
// POWERUP | counting power-up clocks before the first CMD0
// ISSUE   | one-cycle sd_start pulse for the command in cmd_q
// WAIT    | waiting for sd_done, then checking the response
// GAP     | idle spacing after a busy ACMD41 before the next CMD55
// DONE    | card initialised, init_done held
// ERROR   | sequence failed, error_code held
module sd_init_sequencer #(
    parameter int POWERUP_CYCLES = 80,
    parameter int CMD0_RETRIES   = 8,
    parameter int ACMD41_RETRIES = 255,
    parameter int RETRY_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  sd_cmd,
    output logic [31:0] sd_arg,
    output logic [6:0]  sd_crc,
    output logic [2:0]  sd_nresponse,
    output logic        sd_start,
    input  logic        sd_done,
    input  logic [7:0]  resp_r1,
    input  logic [31:0] resp_ext,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic [2:0]  error_code,
    output logic        card_v2,
    output logic        card_sdhc
);
    localparam int TMR_MAX0 = (POWERUP_CYCLES > RETRY_GAP) ? POWERUP_CYCLES : RETRY_GAP;
    localparam int TMR_MAX  = (TMR_MAX0 > TIMEOUT_CYCLES) ? TMR_MAX0 : TIMEOUT_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int C0_W     = $clog2(CMD0_RETRIES + 1);
    localparam int A41_W    = $clog2(ACMD41_RETRIES + 1);

    localparam logic [TMR_W-1:0] PWR_LAST = TMR_W'(POWERUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(RETRY_GAP - 1);
    // ISSUE cycle plus the registered transition: error shows TIMEOUT_CYCLES after sd_start
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 2);
    localparam logic [C0_W-1:0]  C0_MAX   = C0_W'(CMD0_RETRIES);
    localparam logic [A41_W-1:0] A41_MAX  = A41_W'(ACMD41_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_POWERUP, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
    } cmd_t;

    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
    logic [C0_W-1:0]    c0_cnt_q, c0_cnt_d, c0_inc;
    logic [A41_W-1:0]   a41_cnt_q, a41_cnt_d, a41_inc;
    logic [2:0]         err_q, err_d;
    logic               v2_q, v2_d;
    logic               sdhc_q, sdhc_d;
    logic               unused_ext;

    assign unused_ext = ^{resp_ext[31], resp_ext[29:12]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= C_CMD0;
            tmr_q     <= '0;
            c0_cnt_q  <= '0;
            a41_cnt_q <= '0;
            err_q     <= '0;
            v2_q      <= 1'b0;
            sdhc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tmr_q     <= tmr_d;
            c0_cnt_q  <= c0_cnt_d;
            a41_cnt_q <= a41_cnt_d;
            err_q     <= err_d;
            v2_q      <= v2_d;
            sdhc_q    <= sdhc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tmr_d     = tmr_q;
        c0_cnt_d  = c0_cnt_q;
        a41_cnt_d = a41_cnt_q;
        err_d     = err_q;
        v2_d      = v2_q;
        sdhc_d    = sdhc_q;
        tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
        c0_inc    = (c0_cnt_q == '1) ? c0_cnt_q : c0_cnt_q + 1'b1;
        a41_inc   = (a41_cnt_q == '1) ? a41_cnt_q : a41_cnt_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_POWERUP;
                    cmd_d     = C_CMD0;
                    tmr_d     = '0;
                    c0_cnt_d  = '0;
                    a41_cnt_d = '0;
                    err_d     = '0;
                    v2_d      = 1'b0;
                    sdhc_d    = 1'b0;
                end
            end
            S_POWERUP: begin
                if (tmr_q == PWR_LAST) begin
                    state_d = S_ISSUE;
                    cmd_d   = C_CMD0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                tmr_d   = '0;
                if (cmd_q == C_CMD0)
                    c0_cnt_d = c0_inc;
            end
            S_WAIT: begin
                if (sd_done) begin
                    state_d = S_ISSUE;
                    case (cmd_q)
                        C_CMD0: begin
                            if (resp_r1 == 8'h01) begin
                                cmd_d = C_CMD8;
                            end else if (c0_cnt_q >= C0_MAX) begin
                                state_d = S_ERROR;
                                err_d   = 3'd1;
                            end
                        end
                        C_CMD8: begin
                            if (resp_r1 == 8'h01 && resp_ext[11:0] == 12'h1AA) begin
                                v2_d  = 1'b1;
                                cmd_d = C_CMD55;
                            end else if (resp_r1 == 8'h05) begin
                                v2_d  = 1'b0;
                                cmd_d = C_CMD55;
                            end else begin
                                state_d = S_ERROR;
                                err_d   = 3'd2;
                            end
                        end
                        C_CMD55: begin
                            if (resp_r1 == 8'h00 || resp_r1 == 8'h01) begin
                                cmd_d = C_ACMD41;
                            end else begin
                                state_d = S_ERROR;
                                err_d   = 3'd3;
                            end
                        end
                        C_ACMD41: begin
                            if (resp_r1 == 8'h00) begin
                                cmd_d = C_CMD58;
                            end else if (resp_r1 == 8'h01) begin
                                a41_cnt_d = a41_inc;
                                if (a41_inc == A41_MAX) begin
                                    state_d = S_ERROR;
                                    err_d   = 3'd4;
                                end else begin
                                    state_d = S_GAP;
                                    tmr_d   = '0;
                                    cmd_d   = C_CMD55;
                                end
                            end else begin
                                state_d = S_ERROR;
                                err_d   = 3'd3;
                            end
                        end
                        C_CMD58: begin
                            if (resp_r1 == 8'h00) begin
                                sdhc_d  = v2_q & resp_ext[30];
                                state_d = S_DONE;
                            end else begin
                                state_d = S_ERROR;
                                err_d   = 3'd5;
                            end
                        end
                        default: begin
                            state_d = S_ERROR;
                            err_d   = 3'd3;
                        end
                    endcase
                end else if (tmr_q == TO_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 3'd6;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST)
                    state_d = S_ISSUE;
                else
                    tmr_d = tmr_inc;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fields are only driven while a command is outstanding, so they read 0 otherwise
    always_comb begin
        sd_cmd       = '0;
        sd_arg       = '0;
        sd_crc       = '0;
        sd_nresponse = '0;
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            case (cmd_q)
                C_CMD0: sd_crc = 7'h4A;
                C_CMD8: begin
                    sd_cmd       = 6'd8;
                    sd_arg       = 32'h0000_01AA;
                    sd_crc       = 7'h43;
                    sd_nresponse = 3'd4;
                end
                C_CMD55: begin
                    sd_cmd = 6'd55;
                    sd_crc = 7'h32;
                end
                C_ACMD41: begin
                    sd_cmd = 6'd41;
                    sd_arg = v2_q ? 32'h4000_0000 : 32'h0000_0000;
                    sd_crc = v2_q ? 7'h3B : 7'h72;
                end
                C_CMD58: begin
                    sd_cmd       = 6'd58;
                    sd_crc       = 7'h7E;
                    sd_nresponse = 3'd4;
                end
                default: sd_cmd = '0;
            endcase
        end
    end

    assign sd_start   = (state_q == S_ISSUE);
    assign busy       = (state_q == S_POWERUP) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT) || (state_q == S_GAP);
    assign init_done  = (state_q == S_DONE);
    assign init_error = (state_q == S_ERROR);
    assign error_code = err_q;
    assign card_v2    = v2_q;
    assign card_sdhc  = sdhc_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: emulates sd_controller responses step by step.
module tb_sd_init_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, sd_done;
    logic [7:0]  resp_r1;
    logic [31:0] resp_ext;
    logic [5:0]  sd_cmd;
    logic [31:0] sd_arg;
    logic [6:0]  sd_crc;
    logic [2:0]  sd_nresponse;
    logic        sd_start, busy, init_done, init_error, card_v2, card_sdhc;
    logic [2:0]  error_code;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sd_init_sequencer #(
        .POWERUP_CYCLES(4),
        .CMD0_RETRIES(3),
        .ACMD41_RETRIES(2),
        .RETRY_GAP(16),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .sd_cmd(sd_cmd), .sd_arg(sd_arg), .sd_crc(sd_crc), .sd_nresponse(sd_nresponse),
        .sd_start(sd_start), .sd_done(sd_done), .resp_r1(resp_r1), .resp_ext(resp_ext),
        .busy(busy), .init_done(init_done), .init_error(init_error),
        .error_code(error_code), .card_v2(card_v2), .card_sdhc(card_sdhc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {7'd0, sd_cmd, sd_arg, sd_crc, sd_nresponse, sd_start, busy,
                init_done, init_error, error_code, card_v2, card_sdhc};
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (sd_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sd_start !== 1'b1) chk("sd_start_wait", sd_start, 1);
    endtask

    task automatic cmd_step(input string tag, input logic [5:0] c, input logic [31:0] a,
                            input logic [6:0] crc, input logic [2:0] nr,
                            input logic [7:0] r1, input logic [31:0] ext, output int n);
        wait_start(n);
        chk({tag, "_fields"}, {sd_cmd, sd_arg, sd_crc, sd_nresponse}, {c, a, crc, nr});
        @(negedge clk);
        chk({tag, "_pulse"}, sd_start, 0);
        chk({tag, "_hold"}, {sd_cmd, sd_arg, sd_crc, sd_nresponse}, {c, a, crc, nr});
        @(negedge clk);
        sd_done = 1'b1; resp_r1 = r1; resp_ext = ext;
        @(negedge clk);
        sd_done = 1'b0; resp_r1 = 8'h00; resp_ext = 32'h0;
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; start = 1'b0; sd_done = 1'b0; resp_r1 = 8'h00; resp_ext = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        // v2 card with one busy ACMD41
        pulse_start();
        chk("v2_busy", {busy, init_done}, 2'b10);
        cmd_step("v2_cmd0", 6'd0, 32'h0, 7'h4A, 3'd0, 8'h01, 32'h0, n);
        chk("powerup_len", n, 4);
        cmd_step("v2_cmd8", 6'd8, 32'h1AA, 7'h43, 3'd4, 8'h01, 32'h0000_01AA, n);
        chk("v2_cmd8_latency", n, 0);
        cmd_step("v2_cmd55a", 6'd55, 32'h0, 7'h32, 3'd0, 8'h01, 32'h0, n);
        cmd_step("v2_acmd41a", 6'd41, 32'h4000_0000, 7'h3B, 3'd0, 8'h01, 32'h0, n);
        cmd_step("v2_cmd55b", 6'd55, 32'h0, 7'h32, 3'd0, 8'h01, 32'h0, n);
        chk("v2_gap_len", n, 16);
        cmd_step("v2_acmd41b", 6'd41, 32'h4000_0000, 7'h3B, 3'd0, 8'h00, 32'h0, n);
        cmd_step("v2_cmd58", 6'd58, 32'h0, 7'h7E, 3'd4, 8'h00, 32'hC0FF_8000, n);
        chk("v2_final", {busy, init_done, init_error, error_code, card_v2, card_sdhc},
            {1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1});
        sd_done = 1'b1; resp_r1 = 8'hFF;
        @(negedge clk);
        sd_done = 1'b0; resp_r1 = 8'h00;
        @(negedge clk);
        chk("done_ignores_sd_done", {init_done, init_error, sd_start}, 3'b100);

        // v1 card
        pulse_start();
        chk("v1_clear", {busy, init_done, card_v2, card_sdhc}, 4'b1000);
        cmd_step("v1_cmd0", 6'd0, 32'h0, 7'h4A, 3'd0, 8'h01, 32'h0, n);
        cmd_step("v1_cmd8", 6'd8, 32'h1AA, 7'h43, 3'd4, 8'h05, 32'h0, n);
        cmd_step("v1_cmd55", 6'd55, 32'h0, 7'h32, 3'd0, 8'h01, 32'h0, n);
        cmd_step("v1_acmd41", 6'd41, 32'h0, 7'h72, 3'd0, 8'h00, 32'h0, n);
        cmd_step("v1_cmd58", 6'd58, 32'h0, 7'h7E, 3'd4, 8'h00, 32'h80FF_8000, n);
        chk("v1_final", {busy, init_done, init_error, card_v2, card_sdhc}, 5'b01000);

        // CMD0 never answers idle
        pulse_start();
        cmd_step("c0_try1", 6'd0, 32'h0, 7'h4A, 3'd0, 8'hFF, 32'h0, n);
        cmd_step("c0_try2", 6'd0, 32'h0, 7'h4A, 3'd0, 8'hFF, 32'h0, n);
        cmd_step("c0_try3", 6'd0, 32'h0, 7'h4A, 3'd0, 8'hFF, 32'h0, n);
        chk("c0_error", {busy, init_done, init_error, error_code}, {3'b001, 3'd1});
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (sd_start) seen++;
        end
        chk("c0_no_more_start", seen, 0);

        // ACMD41 stays busy
        pulse_start();
        chk("a41_clear", {init_error, error_code}, 4'd0);
        cmd_step("a41_cmd0", 6'd0, 32'h0, 7'h4A, 3'd0, 8'h01, 32'h0, n);
        cmd_step("a41_cmd8", 6'd8, 32'h1AA, 7'h43, 3'd4, 8'h01, 32'h0000_01AA, n);
        cmd_step("a41_cmd55a", 6'd55, 32'h0, 7'h32, 3'd0, 8'h01, 32'h0, n);
        cmd_step("a41_acmd41a", 6'd41, 32'h4000_0000, 7'h3B, 3'd0, 8'h01, 32'h0, n);
        cmd_step("a41_cmd55b", 6'd55, 32'h0, 7'h32, 3'd0, 8'h00, 32'h0, n);
        chk("a41_gap_len", n, 16);
        cmd_step("a41_acmd41b", 6'd41, 32'h4000_0000, 7'h3B, 3'd0, 8'h01, 32'h0, n);
        chk("a41_error", {busy, init_error, error_code}, {2'b01, 3'd4});

        // sd_done never arrives for CMD8
        pulse_start();
        cmd_step("to_cmd0", 6'd0, 32'h0, 7'h4A, 3'd0, 8'h01, 32'h0, n);
        wait_start(n);
        chk("to_cmd8_issue", sd_cmd, 6'd8);
        repeat (31) @(negedge clk);
        chk("to_before", {busy, init_error, error_code}, {2'b10, 3'd0});
        @(negedge clk);
        chk("to_after", {busy, init_error, error_code}, {2'b01, 3'd6});
        pulse_start();
        chk("to_restart_clear", {busy, init_error, error_code}, {2'b10, 3'd0});
        cmd_step("rs_cmd0", 6'd0, 32'h0, 7'h4A, 3'd0, 8'h01, 32'h0, n);
        chk("rs_powerup_len", n, 4);
        cmd_step("rs_cmd8", 6'd8, 32'h1AA, 7'h43, 3'd4, 8'h01, 32'h0000_01AA, n);
        cmd_step("rs_cmd55", 6'd55, 32'h0, 7'h32, 3'd0, 8'h01, 32'h0, n);

        // reset while waiting on ACMD41
        wait_start(n);
        @(negedge clk);
        chk("rs_pre", {busy, card_v2, sd_cmd}, {2'b11, 6'd41});
        rst = 1'b1;
        #1;
        chk("rs_immediate", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (sd_start || busy) seen++;
        end
        chk("rs_quiet", seen, 0);

        // start while busy must not restart power-up
        pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_start(n);
        chk("busy_start_ignored", n, 2);
        chk("busy_start_cmd0", {sd_cmd, sd_crc}, {6'd0, 7'h4A});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/sd_init_sequencer.md
Name: sd_init_sequencer

Overview:
- Upstream command source for sd_controller. Runs the SPI-mode SD card initialisation sequence: power-up wait, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
- Drives sd_controller's cmd/arg/crc/nresponse/start inputs and evaluates each returned response.
- Reports ready/error status and card capacity class to top-level logic (LEDs, later the block-read engine).

Parameters:
- POWERUP_CYCLES, 80, clk cycles waited after start before CMD0 (≥74 required by card).
- CMD0_RETRIES, 8, CMD0 attempts before error.
- ACMD41_RETRIES, 255, ACMD41 attempts before error.
- RETRY_GAP, 16, idle cycles between a busy ACMD41 response and the next CMD55.
- TIMEOUT_CYCLES, 1024, max cycles waiting for sd_done per command.

Ports:
- clk  in  1  system clock (same divided clock as sd_controller)
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin initialisation; sampled only in IDLE/DONE/ERROR
- sd_cmd  out  6  command index to sd_controller
- sd_arg  out  32  command argument
- sd_crc  out  7  CRC7 (without end bit)
- sd_nresponse  out  3  response bytes after R1 (0 or 4)
- sd_start  out  1  one-cycle command launch pulse
- sd_done  in  1  one-cycle pulse; resp_r1/resp_ext valid this cycle
- resp_r1  in  8  R1 byte
- resp_ext  in  32  trailing bytes, MSB first (R7/OCR)
- busy  out  1  sequence in progress
- init_done  out  1  card ready
- init_error  out  1  sequence failed
- error_code  out  3  1=CMD0, 2=CMD8, 3=bad R1, 4=ACMD41 timeout, 5=CMD58, 6=sd_done timeout
- card_v2  out  1  card accepted CMD8
- card_sdhc  out  1  OCR CCS bit (block addressing)

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. A reset asserted mid-sequence aborts immediately. No sd_start is emitted until a new start.
- States: IDLE, POWERUP, ISSUE, WAIT, GAP, DONE, ERROR. A command register (CMD0/CMD8/CMD55/ACMD41/CMD58) selects the field values driven in ISSUE and the check applied in WAIT.
- start in IDLE/DONE/ERROR:
  - clears init_done, init_error, error_code, card_v2, card_sdhc and the retry counters;
  - sets busy; enters POWERUP.
  - start while busy is ignored.
- POWERUP: counts POWERUP_CYCLES cycles, then goes to ISSUE with CMD0.
- ISSUE:
  - sd_cmd, sd_arg, sd_crc and sd_nresponse are stable from this cycle until leaving WAIT.
  - sd_start=1 for exactly this cycle; next state is WAIT.
  - The timeout counter clears here.
- Command fields (cmd, arg, crc, nresponse):
  - CMD0: 0, 0, 7'h4A, 0
  - CMD8: 8, 32'h000001AA, 7'h43, 4
  - CMD55: 55, 0, 7'h32, 0
  - ACMD41 with card_v2: 41, 32'h40000000, 7'h3B, 0
  - ACMD41 without card_v2: 41, 0, 7'h72, 0
  - CMD58: 58, 0, 7'h7E, 4
- WAIT: the check is evaluated on the sd_done cycle. The next state is registered, so a new ISSUE follows sd_done by 1 cycle.
  - CMD0:
    - R1=8'h01 → CMD8.
    - Otherwise, if attempts < CMD0_RETRIES → reissue CMD0.
    - Otherwise → ERROR, code 1.
  - CMD8:
    - R1=8'h01 and resp_ext[11:0]=12'h1AA → card_v2=1, then CMD55.
    - R1=8'h05 (illegal command) → card_v2=0, then CMD55.
    - Otherwise → ERROR, code 2.
  - CMD55:
    - R1 ∈ {8'h00, 8'h01} → ACMD41.
    - Otherwise → ERROR, code 3.
  - ACMD41:
    - R1=8'h00 → CMD58.
    - R1=8'h01 → attempt counter increments. If the count equals ACMD41_RETRIES → ERROR, code 4. Otherwise → GAP.
    - Otherwise → ERROR, code 3.
  - CMD58:
    - R1=8'h00 → card_sdhc = card_v2 & resp_ext[30], then DONE.
    - Otherwise → ERROR, code 5.
  - Timeout counter reaches TIMEOUT_CYCLES with no sd_done → ERROR, code 6. If sd_done and timeout occur in the same cycle, sd_done wins.
- GAP: waits RETRY_GAP cycles, then goes to ISSUE with CMD55.
- DONE: busy=0, init_done=1; held until the next start or reset.
- ERROR: busy=0, init_error=1, error_code held until the next start or reset.
- sd_done outside WAIT is ignored.
- Counters are sized with $clog2(param+1) and saturate; they never wrap.

Test Plan:
- v2 card (POWERUP_CYCLES=4), responses in order: CMD0 R1=01; CMD8 R1=01 ext=000001AA; CMD55 01; ACMD41 01; CMD55 01; ACMD41 00; CMD58 00 ext=C0FF8000.
  - Required: exact cmd/arg/crc sequence 0, 8, 55, 41, 55, 41, 58. ACMD41 arg=40000000.
  - Final state: init_done=1, card_v2=1, card_sdhc=1, busy=0.
- v1 card: CMD8 R1=05; ACMD41 R1=00; CMD58 ext=80FF8000.
  - Required: ACMD41 arg=0, crc=72; card_v2=0, card_sdhc=0, init_done=1.
- CMD0 always returns FF with CMD0_RETRIES=3.
  - Required: exactly 3 CMD0 issues, then init_error=1, error_code=1, and no further sd_start.
- ACMD41 always returns 01 with ACMD41_RETRIES=2.
  - Required: 2 CMD55/ACMD41 pairs with ≥RETRY_GAP idle cycles between them; then error_code=4.
- sd_done never arrives after CMD8 (TIMEOUT_CYCLES=32).
  - Required: error_code=6 exactly 32 cycles after the CMD8 sd_start.
  - Then pulse start: flags clear and POWERUP restarts.
- rst pulsed while in WAIT for ACMD41.
  - Required: all outputs 0 immediately; no sd_start until start. start is ignored while busy=1.
